dmem_arbiter: RTL
=================

# dmem_arbiter

Shares the single-port data memory (`dmem`, 4096 x 32, asynchronous read, write on posedge) among `NREQ` requesters, e.g. CPU load/store unit, a DMA engine and a debug loader. Each cycle at most one requester is granted; its write commits at the next edge and its read data is returned one cycle later through a registered path. Arbitration is round-robin with a bounded burst, so a streaming requester cannot starve the others. The block sits between the requesters and `dmem` and drives all of `dmem`'s inputs.

## Interface
- `NREQ`, 2: number of requesters (2..8)
- `AW`, 12: word-address width, matching `dmem`
- `DW`, 32: data width
- `BURST_MAX`, 4: maximum consecutive grants to one requester while another is waiting (>=1)

Ports:
- `clock`  in  1: system clock
- `reset`  in  1: asynchronous, active-high reset
- `req`  in  NREQ: access request, one bit per requester
- `we_in`  in  NREQ: write enable per requester (meaningful only with `req`)
- `addr_in`  in  NREQ*AW: flattened addresses; requester i at `[i*AW +: AW]`
- `wd_in`  in  NREQ*DW: flattened write data; requester i at `[i*DW +: DW]`
- `gnt`  out  NREQ: one-hot or zero, combinational, same cycle as winning `req`
- `rvalid`  out  NREQ: one-cycle pulse to the requester whose read was granted in the previous cycle
- `rdata`  out  DW: registered read data, shared and qualified by `rvalid`
- `mem_we`  out  1: to `dmem.we`
- `mem_addr`  out  AW: to `dmem.addr`
- `mem_wd`  out  DW: to `dmem.wd`
- `mem_rd`  in  DW: from `dmem.rd`

## Operation
- Registered state:
  - `owner` (index of the last granted requester); reset value NREQ-1, so requester 0 wins first.
  - `cnt` (consecutive grants to `owner`, saturating at BURST_MAX); reset value 0.
  - `busy` flag: IDLE (0) or HOLD (1); reset value IDLE.
- Winner selection (combinational):
  - If HOLD, `req[owner]` is high, and (`cnt` < BURST_MAX or no other `req` bit is set): the winner is `owner`.
  - Otherwise the winner is the first set `req` bit scanning owner+1, owner+2, … modulo NREQ. The scan includes `owner` last.
  - No `req` bit set: no winner, `gnt` = 0.
- Mem drive:
  - `mem_addr` and `mem_wd` are muxed from the winner; both are 0 when there is no winner.
  - `mem_we` = winner's `we_in`, else 0.
- State update at posedge:
  - Winner == `owner` and busy: `cnt` <= min(cnt+1, BURST_MAX).
  - New winner: `owner` <= winner, `cnt` <= 1, busy <= 1.
  - No winner: busy <= 0, `cnt` <= 0, `owner` unchanged (it is the rotation pointer).
- Read return:
  - If the winner's `we_in` = 0: `rdata` <= `mem_rd` and `rvalid[winner]` <= 1 at the edge.
  - Otherwise `rvalid` <= 0. `rdata` holds its value when no read is granted.
- Requesters hold `req`, `we_in`, `addr_in` and `wd_in` stable until they see `gnt`. A requester may drop `req` without being granted.

## Timing
- Grant latency: 0 cycles (combinational) when uncontended.
- Write: committed at the posedge ending the grant cycle.
- Read: `rvalid` and `rdata` are valid in the cycle after `gnt`. Back-to-back reads by one requester give one `rvalid` per cycle.
- Worst-case wait for a requester holding `req`: (NREQ-1)*BURST_MAX cycles.
- Reset values: `gnt`=0, `mem_we`=0, `mem_addr`=0, `mem_wd`=0 (all forced while `reset` is high), `rvalid`=0, `rdata`=0.
- Reset asserted mid-burst: `mem_we` drops immediately, so no write commits at the next edge. A pending `rvalid` is cleared. After release, arbitration restarts with requester 0 first.
- Simultaneous requests: resolved strictly by the rotation order above; never more than one `gnt` bit set.
- Requester drops `req` in HOLD: another requester is granted in the same cycle, or the block goes IDLE.

## Structure
- `mem_pkg`: `DMEM_AW` = 12, `DMEM_DW` = 32, `dmem_req_t` struct (`we`, `addr`, `wd`) for the requester side.
- One sub-module: `rr_pick`, a combinational round-robin first-set search from a start index (parameter NREQ). It is reusable by a future I/O bus arbiter.
- The `dmem` instance lives in the SoC top, not inside this block.

## Test plan
- Single requester: req0 writes 0xDEADBEEF @0x010, then reads 0x010 -> `gnt`=01 both cycles; `rvalid[0]` in the cycle after the read; `rdata`=0xDEADBEEF.
- Both request continuously from reset release (NREQ=2, BURST_MAX=4) -> `gnt` sequence 0,0,0,0,1,1,1,1,0,…; never both bits set.
- req1 alone streams 10 reads of 0x000..0x009 (dmem preloaded with addr+1) -> uncontended, so `gnt[1]` stays high for all 10 cycles; `rdata` = 1..10 each with `rvalid[1]`.
- Owner drops `req` after 2 grants while req1 is pending -> req1 granted in the same cycle; `cnt` restarts at 1.
- Reset asserted in a write-grant cycle (req0, data 0x12345678 @0x020) -> `mem_we`=0 immediately; ram[0x020] unchanged (0); `rvalid`=0.
- NREQ=3, all requesting, BURST_MAX=1 -> grants rotate 0,1,2,0,1,2; max wait per requester is 2 cycles.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and sizes for the data-memory port and its requesters.
package mem_pkg;

  localparam int DMEM_AW = 12;
  localparam int DMEM_DW = 32;

  typedef struct packed {
    logic               we;
    logic [DMEM_AW-1:0] addr;
    logic [DMEM_DW-1:0] wd;
  } dmem_req_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } busy_t;

  // Index width that stays at least one bit for a single-entry range.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin first-set search: returns the first set req bit found scanning
// start, start+1, ... modulo NREQ.
module rr_pick
  import mem_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   start,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  int                pos;

  assign dbl = {req, req};
  assign rot = NREQ'(dbl >> start);

  // Descending scan so the smallest offset from start wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        pos = int'(start) + k;
        if (pos >= NREQ) pos = pos - NREQ;
        valid = 1'b1;
        idx   = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter with bounded bursts sharing one single-port dmem.
// state | meaning
// IDLE  | no grant last cycle; winner comes from the rotation scan
// HOLD  | owner was granted last cycle and may keep the port up to BURST_MAX
module dmem_arbiter
  import mem_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int AW        = DMEM_AW,
  parameter int DW        = DMEM_DW,
  parameter int BURST_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   we_in,
  input  logic [NREQ*AW-1:0] addr_in,
  input  logic [NREQ*DW-1:0] wd_in,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rvalid,
  output logic [DW-1:0]     rdata,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wd,
  input  logic [DW-1:0]     mem_rd
);

  localparam int IW = idx_w(NREQ);
  localparam int CW = $clog2(BURST_MAX + 1);

  busy_t           busy_q, busy_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   start, pick_idx, win;
  logic            pick_valid, hold_win, win_valid, rd_hit;
  logic [NREQ-1:0] others;

  // Scan starts just past the owner, so the owner itself is considered last.
  assign start  = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);
  assign others = req & ~(NREQ'(1) << owner_q);

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req   (req),
    .start (start),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    busy_d    = busy_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    hold_win  = (busy_q == HOLD) && req[owner_q] &&
                ((cnt_q < CW'(BURST_MAX)) || (others == '0));
    win_valid = !reset && (hold_win || pick_valid);
    win       = hold_win ? owner_q : pick_idx;
    if (!win_valid) begin
      busy_d = IDLE;
      cnt_d  = '0;
    end else if ((busy_q == HOLD) && (win == owner_q)) begin
      if (cnt_q != CW'(BURST_MAX)) cnt_d = cnt_q + CW'(1);
    end else begin
      owner_d = win;
      cnt_d   = CW'(1);
      busy_d  = HOLD;
    end
  end

  always_comb begin
    gnt      = '0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    rd_hit   = 1'b0;
    if (win_valid) begin
      gnt[win] = 1'b1;
      mem_we   = we_in[win];
      mem_addr = addr_in[int'(win)*AW +: AW];
      mem_wd   = wd_in[int'(win)*DW +: DW];
      rd_hit   = !we_in[win];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q  <= IDLE;
      owner_q <= IW'(NREQ - 1);
      cnt_q   <= '0;
      rvalid  <= '0;
      rdata   <= '0;
    end else begin
      busy_q  <= busy_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      rvalid  <= rd_hit ? gnt : '0;
      if (rd_hit) rdata <= mem_rd;
    end
  end

endmodule
